// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV64 sequencer: FSM states, opcodes,
// instruction classes and ALU operation selects.
package mc_pkg;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_TRAP   = 3'd5;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef enum logic [2:0] {
      CLS_R  = 3'd0,
      CLS_I  = 3'd1,
      CLS_LD = 3'd2,
      CLS_ST = 3'd3,
      CLS_BR = 3'd4
   } cls_e;

   function automatic logic [1:0] cls_alu_op(input cls_e c);
      case (c)
         CLS_R, CLS_I: cls_alu_op = ALU_FUNCT;
         CLS_BR:       cls_alu_op = ALU_SUB;
         default:      cls_alu_op = ALU_ADD;
      endcase
   endfunction

   function automatic logic cls_uses_imm(input cls_e c);
      cls_uses_imm = (c == CLS_I) || (c == CLS_LD) || (c == CLS_ST);
   endfunction

endpackage

// File: rtl/mc_opdecode.sv
// Combinational opcode classifier: maps instr[6:0] to an instruction class
// and flags opcodes the sequencer does not support.
module mc_opdecode
   import mc_pkg::*;
(
   input  logic [6:0] i_opcode,
   output cls_e       o_cls,
   output logic       o_legal
);

   always_comb begin
      o_cls   = CLS_R;
      o_legal = 1'b1;
      case (i_opcode)
         OP_R:    o_cls = CLS_R;
         OP_I:    o_cls = CLS_I;
         OP_LD:   o_cls = CLS_LD;
         OP_ST:   o_cls = CLS_ST;
         OP_BR:   o_cls = CLS_BR;
         default: o_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory-timeout and
// illegal-opcode traps. Define MC_PERF_CNT_EN to build the cycle/instret counters.
module multicycle_controller
   import mc_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int PERF_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [6:0]        opcode,
   input  logic              zero,
   input  logic              imem_ready,
   input  logic              dmem_ready,
   output logic              imem_req,
   output logic              dmem_read,
   output logic              dmem_write,
   output logic              ir_write,
   output logic              pc_write,
   output logic              pc_src,
   output logic              alu_src,
   output logic [1:0]        alu_op,
   output logic              reg_write,
   output logic              mem_to_reg,
   output logic              illegal,
   output logic              mem_fault,
   output logic              halted,
   output logic [PERF_W-1:0] cycle_cnt,
   output logic [PERF_W-1:0] instret_cnt
);

   localparam int              TO_W    = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

   logic [2:0]      r_state;
   logic [2:0]      w_state_nxt;
   cls_e            r_cls;
   cls_e            w_dec_cls;
   logic            w_dec_legal;
   logic [TO_W-1:0] r_to_cnt;
   logic            r_illegal;
   logic            r_mem_fault;
   logic            w_wait;
   logic            w_ready;
   logic            w_to_hit;
   logic            w_enter_wait;
   logic            w_take_br;

   mc_opdecode u_opdecode (
      .i_opcode (opcode),
      .o_cls    (w_dec_cls),
      .o_legal  (w_dec_legal)
   );

   assign w_wait    = (r_state == S_FETCH) || (r_state == S_MEM);
   assign w_ready   = (r_state == S_FETCH) ? imem_ready : dmem_ready;
   // A ready on the last allowed cycle still completes the access.
   assign w_to_hit  = w_wait && !w_ready && (r_to_cnt == TO_LAST);
   assign w_take_br = (r_state == S_EXEC) && (r_cls == CLS_BR) && zero;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_FETCH: begin
            if (imem_ready)    w_state_nxt = S_DECODE;
            else if (w_to_hit) w_state_nxt = S_TRAP;
         end
         S_DECODE: w_state_nxt = w_dec_legal ? S_EXEC : S_TRAP;
         S_EXEC: begin
            case (r_cls)
               CLS_BR:       w_state_nxt = S_FETCH;
               CLS_R, CLS_I: w_state_nxt = S_WB;
               default:      w_state_nxt = S_MEM;
            endcase
         end
         S_MEM: begin
            if (dmem_ready)    w_state_nxt = (r_cls == CLS_ST) ? S_FETCH : S_WB;
            else if (w_to_hit) w_state_nxt = S_TRAP;
         end
         S_WB:    w_state_nxt = S_FETCH;
         S_TRAP:  w_state_nxt = S_TRAP;
         default: w_state_nxt = S_TRAP;
      endcase
   end

   assign w_enter_wait = ((w_state_nxt == S_FETCH) || (w_state_nxt == S_MEM)) &&
                         (w_state_nxt != r_state);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_FETCH;
         r_cls       <= CLS_R;
         r_to_cnt    <= '0;
         r_illegal   <= 1'b0;
         r_mem_fault <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_DECODE) r_cls <= w_dec_cls;
         if (w_enter_wait)            r_to_cnt <= '0;
         else if (w_wait && !w_ready) r_to_cnt <= r_to_cnt + 1'b1;
         if ((r_state == S_DECODE) && !w_dec_legal) r_illegal <= 1'b1;
         if (w_to_hit) r_mem_fault <= 1'b1;
      end
   end

`ifdef MC_PERF_CNT_EN
   logic [PERF_W-1:0] r_cycle_cnt;
   logic [PERF_W-1:0] r_instret_cnt;
   logic              w_retire;

   assign w_retire = (w_state_nxt == S_FETCH) &&
                     ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cycle_cnt   <= '0;
         r_instret_cnt <= '0;
      end else begin
         if (r_state != S_TRAP) r_cycle_cnt   <= r_cycle_cnt + 1'b1;
         if (w_retire)          r_instret_cnt <= r_instret_cnt + 1'b1;
      end
   end

   assign cycle_cnt   = r_cycle_cnt;
   assign instret_cnt = r_instret_cnt;
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

   // Strobes and flags are held low while reset is asserted.
   always_comb begin
      imem_req   = 1'b0;
      dmem_read  = 1'b0;
      dmem_write = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_src    = 1'b0;
      alu_op     = ALU_ADD;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
      mem_fault  = 1'b0;
      halted     = 1'b0;
      if (!reset) begin
         illegal   = r_illegal;
         mem_fault = r_mem_fault;
         case (r_state)
            S_FETCH: begin
               imem_req = 1'b1;
               ir_write = imem_ready;
               pc_write = imem_ready;
            end
            S_EXEC: begin
               alu_src  = cls_uses_imm(r_cls);
               alu_op   = cls_alu_op(r_cls);
               pc_write = w_take_br;
               pc_src   = w_take_br;
            end
            S_MEM: begin
               dmem_read  = (r_cls == CLS_LD);
               dmem_write = (r_cls == CLS_ST);
            end
            S_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = (r_cls == CLS_LD);
            end
            S_TRAP:  halted = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a per-instruction reference
// model queues the expected strobes for every cycle; a monitor compares them.
module tb_multicycle_controller;

   localparam int MT = 16;
   localparam int PW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [6:0]    opcode;
   logic          zero;
   logic          imem_ready;
   logic          dmem_ready;
   logic          imem_req, dmem_read, dmem_write, ir_write, pc_write, pc_src;
   logic          alu_src, reg_write, mem_to_reg, illegal, mem_fault, halted;
   logic [1:0]    alu_op;
   logic [PW-1:0] cycle_cnt;
   logic [PW-1:0] instret_cnt;

   always #5 clk = ~clk;

   multicycle_controller #(.MEM_TIMEOUT(MT), .PERF_W(PW)) dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .zero        (zero),
      .imem_ready  (imem_ready),
      .dmem_ready  (dmem_ready),
      .imem_req    (imem_req),
      .dmem_read   (dmem_read),
      .dmem_write  (dmem_write),
      .ir_write    (ir_write),
      .pc_write    (pc_write),
      .pc_src      (pc_src),
      .alu_src     (alu_src),
      .alu_op      (alu_op),
      .reg_write   (reg_write),
      .mem_to_reg  (mem_to_reg),
      .illegal     (illegal),
      .mem_fault   (mem_fault),
      .halted      (halted),
      .cycle_cnt   (cycle_cnt),
      .instret_cnt (instret_cnt)
   );

   typedef struct packed {
      logic       imem_req;
      logic       dmem_read;
      logic       dmem_write;
      logic       ir_write;
      logic       pc_write;
      logic       pc_src;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       reg_write;
      logic       mem_to_reg;
      logic       illegal;
      logic       mem_fault;
      logic       halted;
   } sig_t;

   typedef struct packed {
      sig_t        s;
      logic [31:0] cyc;
      logic [31:0] ins;
   } exp_t;

   exp_t        q[$];
   exp_t        me;
   sig_t        act;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_cyc  = 0;
   logic [31:0] m_ins  = 0;
   bit          m_ill  = 0;
   bit          m_mf   = 0;

   assign act = {imem_req, dmem_read, dmem_write, ir_write, pc_write, pc_src,
                 alu_src, alu_op, reg_write, mem_to_reg, illegal, mem_fault, halted};

   // Monitor: one expectation per clock cycle, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            me = q.pop_front();
            checks++;
            if (act !== me.s) begin
               errors++;
               $display("FAIL strobes t=%0t actual=%b required=%b", $time, act, me.s);
            end
            checks++;
            if (cycle_cnt !== me.cyc) begin
               errors++;
               $display("FAIL cycle_cnt t=%0t actual=%0d required=%0d", $time, cycle_cnt, me.cyc);
            end
            checks++;
            if (instret_cnt !== me.ins) begin
               errors++;
               $display("FAIL instret_cnt t=%0t actual=%0d required=%0d", $time, instret_cnt, me.ins);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog t=%0t actual=running required=finished", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic logic rb();
      return 1'($urandom % 2);
   endfunction

   function automatic logic [6:0] rop();
      return 7'($urandom);
   endfunction

   // 0 = illegal, 1 R, 2 I, 3 LD, 4 ST, 5 BR
   function automatic int cls_of(input logic [6:0] op);
      case (op)
         7'h33:   return 1;
         7'h13:   return 2;
         7'h03:   return 3;
         7'h23:   return 4;
         7'h63:   return 5;
         default: return 0;
      endcase
   endfunction

   task automatic drive(input logic ir, input logic dr, input logic z, input logic rs,
                        input logic [6:0] op, input sig_t s, input bit retire);
      exp_t e;
      @(posedge clk);
      #1;
      imem_ready = ir;
      dmem_ready = dr;
      zero       = z;
      reset      = rs;
      opcode     = op;
      e.s = s;
`ifdef MC_PERF_CNT_EN
      e.cyc = m_cyc;
      e.ins = m_ins;
`else
      e.cyc = 0;
      e.ins = 0;
`endif
      q.push_back(e);
      if (rs) begin
         m_cyc = 0;
         m_ins = 0;
         m_ill = 0;
         m_mf  = 0;
      end else begin
         if (!s.halted) m_cyc = m_cyc + 1;
         if (retire)    m_ins = m_ins + 1;
      end
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) drive(rb(), rb(), rb(), 1'b1, rop(), '0, 1'b0);
   endtask

   task automatic enter_trap(input bit mf);
      sig_t s;
      int   n;
      if (mf) m_mf = 1;
      else    m_ill = 1;
      n = 20 + int'($urandom % 4);
      for (int i = 0; i < n; i++) begin
         s = '0;
         s.halted    = 1'b1;
         s.illegal   = m_ill;
         s.mem_fault = m_mf;
         drive(rb(), rb(), rb(), 1'b0, rop(), s, 1'b0);
      end
      do_reset(2);
   endtask

   // One instruction: wi/wd = wait cycles before imem/dmem ready.
   task automatic run_instr(input logic [6:0] op, input int wi, input int wd,
                            input logic z, input bit rst_mid);
      sig_t s;
      int   c;
      int   k;
      k = 0;
      forever begin
         s = '0;
         s.imem_req = 1'b1;
         if (k == wi) begin
            s.ir_write = 1'b1;
            s.pc_write = 1'b1;
            drive(1'b1, rb(), rb(), 1'b0, rop(), s, 1'b0);
            break;
         end
         drive(1'b0, rb(), rb(), 1'b0, rop(), s, 1'b0);
         if (k == MT - 1) begin
            enter_trap(1'b1);
            return;
         end
         k++;
      end
      c = cls_of(op);
      drive(rb(), rb(), rb(), 1'b0, op, '0, 1'b0);
      if (c == 0) begin
         enter_trap(1'b0);
         return;
      end
      s = '0;
      s.alu_src = (c == 2) || (c == 3) || (c == 4);
      s.alu_op  = (c == 5) ? 2'b01 : ((c <= 2) ? 2'b10 : 2'b00);
      if (c == 5) begin
         s.pc_write = z;
         s.pc_src   = z;
      end
      drive(rb(), rb(), z, 1'b0, rop(), s, c == 5);
      if (c == 5) return;
      if (c >= 3) begin
         k = 0;
         forever begin
            if (rst_mid && k == 2) return;
            s = '0;
            s.dmem_read  = (c == 3);
            s.dmem_write = (c == 4);
            if (k == wd) begin
               drive(rb(), 1'b1, rb(), 1'b0, rop(), s, c == 4);
               break;
            end
            drive(rb(), 1'b0, rb(), 1'b0, rop(), s, 1'b0);
            if (k == MT - 1) begin
               enter_trap(1'b1);
               return;
            end
            k++;
         end
         if (c == 4) return;
      end
      s = '0;
      s.reg_write  = 1'b1;
      s.mem_to_reg = (c == 3);
      drive(rb(), rb(), rb(), 1'b0, rop(), s, 1'b1);
   endtask

   logic [6:0] legal_ops [5] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63};

   initial begin
      logic [6:0] op;
      int         wi;
      int         wd;
      bit         rm;
      reset      = 1'b1;
      opcode     = '0;
      zero       = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      repeat (3) @(posedge clk);
      do_reset(2);

      run_instr(7'h33, 0, 0, 1'b0, 1'b0);
      run_instr(7'h03, 0, 3, 1'b0, 1'b0);
      run_instr(7'h63, 0, 0, 1'b1, 1'b0);
      run_instr(7'h63, 0, 0, 1'b0, 1'b0);
      run_instr(7'h23, 1, 0, 1'b0, 1'b0);
      run_instr(7'h13, 0, 0, 1'b0, 1'b0);
      run_instr(7'h7F, 0, 0, 1'b0, 1'b0);
      run_instr(7'h33, 16, 0, 1'b0, 1'b0);
      run_instr(7'h33, 15, 0, 1'b0, 1'b0);
      run_instr(7'h03, 0, 16, 1'b0, 1'b0);
      run_instr(7'h23, 0, 15, 1'b0, 1'b0);
      run_instr(7'h23, 0, 10, 1'b0, 1'b1);
      do_reset(2);

      for (int n = 0; n < 80; n++) begin
         if ($urandom % 20 == 0) op = rop();
         else                    op = legal_ops[$urandom % 5];
         wi = ($urandom % 8 == 0) ? int'($urandom_range(0, 17)) : int'($urandom % 3);
         wd = ($urandom % 8 == 0) ? int'($urandom_range(0, 17)) : int'($urandom % 3);
         rm = ($urandom % 25 == 0);
         run_instr(op, wi, wd, rb(), rm);
         if (rm) do_reset(1 + int'($urandom % 2));
      end

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain actual=%0d required=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
